row_scanout: RTL

Downstream display stage for the square-drawing pipeline. It generates 640x480@60 VGA timing and streams the 480-pixel field row out of a ping-pong row buffer, clearing each pixel back to background after reading it. It pulses `swap` once per active line so the row drawer starts filling the other bank, and it pulses `vblank_start` once per frame for the entity-table updater.

---
 rtl/row_scanout.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/row_scanout.sv
// VGA scan-out for the square pipeline: streams the field row out of a ping-pong
// row buffer, clears each pixel after reading it, and produces aligned sync/blank/RGB.
module row_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned FIELD_W  = 480,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [8:0]  rd_addr,
    input  logic [23:0] rd_data,
    output logic [8:0]  clr_addr,
    output logic [23:0] clr_data,
    output logic        clr_wren,
    output logic        bank,
    output logic        swap,
    output logic        vblank_start,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank_n,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
);

    localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] FIELD     = 10'(FIELD_W);
    localparam logic [9:0] SWAP_PRE  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE - 1);

    logic [9:0]  hCount_q, hCount_d;
    logic [9:0]  vCount_q, vCount_d;
    logic        fetch, visible, hsyncRaw, vsyncRaw;
    logic [8:0]  rdAddr_q;
    logic        fetch1_q, visible1_q, hsync1_q, vsync1_q;
    logic [23:0] rgb_q, rgb_d;
    logic        blank_q, hsyncOut_q, vsyncOut_q;
    logic        swap_q, swap_d;
    logic        vblank_q, vblank_d;
    logic        bank_q;

    always_comb begin
        hCount_d = hCount_q + 10'd1;
        vCount_d = vCount_q;
        if (hCount_q == H_LAST) begin
            hCount_d = 10'd0;
            vCount_d = (vCount_q == V_LAST) ? 10'd0 : vCount_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hCount_q <= 10'd0;
            vCount_q <= 10'd0;
        end else begin
            hCount_q <= hCount_d;
            vCount_q <= vCount_d;
        end
    end

    assign fetch    = (hCount_q < FIELD) && (vCount_q < V_ACT);
    assign visible  = (hCount_q < H_ACT) && (vCount_q < V_ACT);
    assign hsyncRaw = !((hCount_q >= HS_FIRST) && (hCount_q <= HS_LAST));
    assign vsyncRaw = !((vCount_q >= VS_FIRST) && (vCount_q <= VS_LAST));

    // The address leaves in the counter's own cycle so the buffer's one-cycle read
    // lands in stage 1; the held copy doubles as the clear address for that stage.
    assign rd_addr  = fetch ? hCount_q[8:0] : rdAddr_q;
    assign clr_addr = rdAddr_q;
    assign clr_wren = fetch1_q;
    assign clr_data = BG_COLOR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdAddr_q   <= 9'd0;
            fetch1_q   <= 1'b0;
            visible1_q <= 1'b0;
            hsync1_q   <= 1'b1;
            vsync1_q   <= 1'b1;
        end else begin
            rdAddr_q   <= rd_addr;
            fetch1_q   <= fetch;
            visible1_q <= visible;
            hsync1_q   <= hsyncRaw;
            vsync1_q   <= vsyncRaw;
        end
    end

    always_comb begin
        rgb_d = 24'd0;
        if (fetch1_q) begin
            rgb_d = rd_data;
        end else if (visible1_q) begin
            rgb_d = BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q      <= 24'd0;
            blank_q    <= 1'b0;
            hsyncOut_q <= 1'b1;
            vsyncOut_q <= 1'b1;
        end else begin
            rgb_q      <= rgb_d;
            blank_q    <= visible1_q;
            hsyncOut_q <= hsync1_q;
            vsyncOut_q <= vsync1_q;
        end
    end

    // Line events are registered from the preceding counter value, so swap is high
    // while h sits at H_ACTIVE and bank flips on that same edge.
    assign swap_d   = (hCount_q == SWAP_PRE) && (vCount_q < V_ACT);
    assign vblank_d = (hCount_q == H_LAST) && (vCount_q == V_ACT_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_q   <= 1'b0;
            vblank_q <= 1'b0;
            bank_q   <= 1'b0;
        end else begin
            swap_q   <= swap_d;
            vblank_q <= vblank_d;
            if (swap_d) begin
                bank_q <= ~bank_q;
            end
        end
    end

    assign swap         = swap_q;
    assign vblank_start = vblank_q;
    assign bank         = bank_q;
    assign hsync_n      = hsyncOut_q;
    assign vsync_n      = vsyncOut_q;
    assign blank_n      = blank_q;
    assign r            = rgb_q[23:16];
    assign g            = rgb_q[15:8];
    assign b            = rgb_q[7:0];

endmodule
